// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute/mem sequencer for the WISC core.
// Owns PC, IR and the Z/N/V flags; commit strobes one cycle per retire.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        dmem_rdy,
  input  logic        alu_zr,
  input  logic        alu_neg,
  input  logic        alu_ov,
  input  logic [15:0] jr_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic [15:0] ir,
  output logic        imem_re,
  output logic        dmem_en,
  output logic        commit,
  output logic        addz_en,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_z;
  logic        r_n;
  logic        r_v;

  logic [3:0]  w_op;
  logic        w_is_mem;
  logic        w_is_hlt;
  logic        w_take;
  logic        w_exec_commit;
  logic [15:0] w_pc1;
  logic [15:0] w_next_pc;

  assign w_op     = r_ir[15:12];
  assign w_is_mem = (w_op == 4'h8) || (w_op == 4'h9);
  assign w_is_hlt = (w_op == 4'hF);
  assign w_pc1    = r_pc + 16'd1;

  assign w_exec_commit = (r_state == S_EXEC) && !w_is_mem && !w_is_hlt;

  always_comb begin
    w_take = 1'b0;
    case (r_ir[11:9])
      3'b000:  w_take = ~r_z;
      3'b001:  w_take = r_z;
      3'b010:  w_take = ~r_z & ~r_n;
      3'b011:  w_take = r_n;
      3'b100:  w_take = r_z | ~r_n;
      3'b101:  w_take = r_z | r_n;
      3'b110:  w_take = r_v;
      default: w_take = 1'b1;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc1;
    case (w_op)
      4'hC: if (w_take)
              w_next_pc = w_pc1 + {{7{r_ir[8]}}, r_ir[8:0]};
      4'hD: w_next_pc = w_pc1 + {{4{r_ir[11]}}, r_ir[11:0]};
      4'hE: w_next_pc = jr_addr;
      default: w_next_pc = w_pc1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_rdy) begin
            r_ir    <= imem_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_mem) begin
            r_state <= S_MEM;
          end else if (w_is_hlt) begin
            r_state <= S_HALT;
          end else begin
            r_pc    <= w_next_pc;
            r_state <= S_FETCH;
            case (w_op)
              4'h0, 4'h2: begin
                r_z <= alu_zr;
                r_n <= alu_neg;
                r_v <= alu_ov;
              end
              // addz only retires its flags when the old Z was set
              4'h1: if (r_z) begin
                r_z <= alu_zr;
                r_n <= alu_neg;
                r_v <= alu_ov;
              end
              4'h3, 4'h4, 4'h5, 4'h6, 4'h7: r_z <= alu_zr;
              default: ;
            endcase
          end
        end
        S_MEM: begin
          if (dmem_rdy) begin
            r_pc    <= w_pc1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_plus1 = w_pc1;
  assign ir       = r_ir;
  assign addz_en  = r_z;
  assign imem_re  = !rst && (r_state == S_FETCH);
  assign dmem_en  = !rst && (r_state == S_MEM);
  assign halted   = !rst && (r_state == S_HALT);
  assign commit   = !rst && (w_exec_commit ||
                    ((r_state == S_MEM) && dmem_rdy));

endmodule
